finn_latency_sink: RTL and testbench
====================================

FINN_LATENCY_SINK -- requirements
Module: finn_latency_sink

Interface
REQ-001 Parameter IN_BEATS, default 10: accepted input-side beats per inference frame.
REQ-002 Parameter OUT_BEATS, default 1: accepted output beats per inference frame.
REQ-003 Parameter TS_DEPTH, default 8 (power of 2): timestamp FIFO depth.
REQ-004 Parameter CNT_W, default 32: width of the cycle counter and all latency values.
REQ-005 ap_clk  in  1  sole clock; one clock domain, all logic on rising edge.
REQ-006 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-007 clear  in  1  synchronous statistics/error clear, active-high.
REQ-008 in_tvalid  in  1  snoop of network input-stream tvalid.
REQ-009 in_tready  in  1  snoop of network input-stream tready.
REQ-010 s_axis_tdata  in  8  network result byte.
REQ-011 s_axis_tvalid  in  1  result valid.
REQ-012 s_axis_tready  out  1  sink ready.
REQ-013 stall_en  in  1  enables deterministic back-pressure.
REQ-014 lat_valid  out  1  one-cycle pulse, new latency sample.
REQ-015 lat_cycles, lat_min, lat_max  out  CNT_W each  last/min/max frame latency.
REQ-016 frame_cnt  out  16  completed frames, saturating at 16'hFFFF.
REQ-017 last_result  out  8  tdata of last accepted output beat.
REQ-018 err_overflow, err_underflow  out  1 each  sticky error flags.

Function
REQ-019 Free-running counter cyc (CNT_W) increments every cycle, wraps modulo 2^CNT_W.
REQ-020 Input handshake = in_tvalid & in_tready; output handshake = s_axis_tvalid & s_axis_tready.
REQ-021 Input beat counter mod IN_BEATS; on handshake with count 0, push cyc into timestamp FIFO.
REQ-022 Output beat counter mod OUT_BEATS; on handshake with count OUT_BEATS-1, pop FIFO head.
REQ-023 Next cycle: lat_valid=1, lat_cycles=(cyc at pop handshake - popped ts) mod 2^CNT_W.
REQ-024 Same update cycle: lat_min/lat_max updated with the new sample; frame_cnt incremented.
REQ-025 last_result updated on every output handshake.
REQ-026 s_axis_tready = 1, except 0 when stall_en=1 and cyc[1:0]==2'b11; also 1 in ERROR.
REQ-027 FSM states IDLE, RUN, ERROR.
REQ-028 IDLE->RUN on first input push; output handshake in IDLE sets err_underflow, ->ERROR.
REQ-029 RUN->ERROR on push while FIFO full and no same-cycle pop (err_overflow=1, push dropped).
REQ-030 RUN->ERROR on pop while FIFO empty, incl. same-cycle push (err_underflow=1).
REQ-031 Simultaneous push and pop with FIFO full: legal, no error.
REQ-032 ERROR: no pushes, pops, or statistics updates; output beats still accepted and discarded.
REQ-033 clear=1 (any state): FIFO and beat counters emptied, stats and flags to reset values, ->IDLE; cyc keeps running.
REQ-034 clear has priority over any same-cycle handshake.

Reset
REQ-035 ap_rst_n=0: state IDLE, cyc=0, FIFO empty, beat counters 0.
REQ-036 Reset outputs: lat_valid=0, lat_cycles=0, lat_min=all-ones, lat_max=0, frame_cnt=0, last_result=0, flags 0, s_axis_tready=0.
REQ-037 Reset mid-frame discards partial frames and all stored timestamps.

Structure
REQ-038 Package finn_lat_pkg holds the state enum and the default IN_BEATS/OUT_BEATS/TS_DEPTH/CNT_W constants.
REQ-039 Timestamp storage is sub-module ts_fifo (synchronous FIFO, full/empty, first-word-fall-through).

Verification
REQ-040 One frame, input beats cyc 20-29, output beat cyc 150 -> lat_cycles=130, min=max=130, frame_cnt=1.
REQ-041 Frames at 20-29 and 84-93, outputs at 150 and 220 -> samples 130, 136; lat_min=130, lat_max=136.
REQ-042 Nine frame starts, no outputs -> err_overflow=1 at ninth start, state ERROR, frame_cnt=0.
REQ-043 Output beat with no prior input -> err_underflow=1, ERROR; clear -> IDLE, flags 0.
REQ-044 CNT_W=8, frame start at cyc 250, output at cyc 4 after wrap -> lat_cycles=10.
REQ-045 stall_en=1, tvalid raised at cyc 3 -> tready=0 at cyc 3, accepted at cyc 4, latency measured from cyc 4.

Source files
------------

// File: rtl/finn_lat_pkg.sv
// Shared definitions for the FINN latency sink.
// Holds the controller state encoding and the default build constants
// used by finn_latency_sink and its timestamp FIFO.
package finn_lat_pkg;

  localparam int unsigned DEF_IN_BEATS  = 10;
  localparam int unsigned DEF_OUT_BEATS = 1;
  localparam int unsigned DEF_TS_DEPTH  = 8;
  localparam int unsigned DEF_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous first-word-fall-through FIFO for frame-start timestamps.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   flush_i         synchronous empty (pointers only)
//   push_i, din_i   write strobe / data
//   pop_i, dout_o   read strobe / head data (valid whenever !empty_o)
//   full_o, empty_o occupancy flags
// Caller guarantees no push when full (unless popping) and no pop when empty.
module ts_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = pop_i  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/finn_latency_sink.sv
// Measures FINN accelerator frame latency by snooping the input stream and
// sinking the result stream.
// Ports:
//   ap_clk, ap_rst_n           clock, synchronous active-low reset
//   clear                      synchronous statistics/error clear
//   in_tvalid, in_tready       snooped input-stream handshake
//   s_axis_*                   result stream sink (tready with optional stall)
//   stall_en                   throttle tready one cycle in four
//   lat_valid, lat_cycles      one-cycle pulse with the newest latency sample
//   lat_min, lat_max           running extremes
//   frame_cnt                  completed frames (saturating)
//   last_result                data of last accepted result beat
//   err_overflow/underflow     sticky timestamp FIFO error flags
module finn_latency_sink
  import finn_lat_pkg::*;
#(
  parameter int unsigned IN_BEATS  = DEF_IN_BEATS,
  parameter int unsigned OUT_BEATS = DEF_OUT_BEATS,
  parameter int unsigned TS_DEPTH  = DEF_TS_DEPTH,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             in_tvalid,
  input  logic             in_tready,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             stall_en,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_cycles,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       last_result,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int unsigned IB_W = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
  localparam int unsigned OB_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q;
  logic [IB_W-1:0]  in_cnt_q;
  logic [OB_W-1:0]  out_cnt_q;
  logic             lat_valid_q, ovf_q, unf_q;
  logic [CNT_W-1:0] lat_cycles_q, lat_min_q, lat_max_q;
  logic [15:0]      frame_cnt_q;
  logic [7:0]       last_result_q;

  logic             in_hs, out_hs, frame_start, frame_end;
  logic             push_ok, pop_ok, set_ovf, set_unf;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_head, sample;

  assign in_hs       = in_tvalid & in_tready;
  assign out_hs      = s_axis_tvalid & s_axis_tready;
  assign frame_start = in_hs && (in_cnt_q == '0);
  assign frame_end   = out_hs && (out_cnt_q == OB_W'(OUT_BEATS - 1));
  assign sample      = cyc_q - fifo_head;

  ts_fifo #(.DEPTH(TS_DEPTH), .W(CNT_W)) u_ts_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .flush_i (clear),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .din_i   (cyc_q),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state and FIFO action decode; clear overrides every handshake.
  always_comb begin
    state_d = state_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_hs) begin
          set_unf = 1'b1;
          state_d = ST_ERROR;
        end else if (frame_start) begin
          push_ok = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end && fifo_empty) begin
          set_unf = 1'b1;
          state_d = ST_ERROR;
        end else if (frame_start && fifo_full && !frame_end) begin
          set_ovf = 1'b1;
          state_d = ST_ERROR;
        end else begin
          push_ok = frame_start;
          pop_ok  = frame_end;
        end
      end
      default: state_d = ST_ERROR;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
    end
  end

  // Output decode: ERROR keeps draining the result stream regardless of stall.
  always_comb begin
    s_axis_tready = 1'b0;
    if (ap_rst_n) begin
      s_axis_tready = (state_q == ST_ERROR) || !(stall_en && (cyc_q[1:0] == 2'b11));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) cyc_q <= '0;
    else           cyc_q <= cyc_q + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (state_q != ST_ERROR) begin
      if (in_hs)
        in_cnt_q <= (in_cnt_q == IB_W'(IN_BEATS - 1)) ? '0 : in_cnt_q + 1'b1;
      if (out_hs)
        out_cnt_q <= (out_cnt_q == OB_W'(OUT_BEATS - 1)) ? '0 : out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) begin
      lat_valid_q   <= 1'b0;
      lat_cycles_q  <= '0;
      lat_min_q     <= '1;
      lat_max_q     <= '0;
      frame_cnt_q   <= '0;
      last_result_q <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      lat_valid_q <= pop_ok;
      ovf_q       <= ovf_q | set_ovf;
      unf_q       <= unf_q | set_unf;
      if (pop_ok) begin
        lat_cycles_q <= sample;
        if (sample < lat_min_q) lat_min_q <= sample;
        if (sample > lat_max_q) lat_max_q <= sample;
        if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (out_hs && state_q != ST_ERROR) last_result_q <= s_axis_tdata;
    end
  end

  assign lat_valid     = lat_valid_q;
  assign lat_cycles    = lat_cycles_q;
  assign lat_min       = lat_min_q;
  assign lat_max       = lat_max_q;
  assign frame_cnt     = frame_cnt_q;
  assign last_result   = last_result_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_finn_latency_sink.sv
module tb_finn_latency_sink;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        stall_en = 1'b0;

  logic        s_axis_tready, lat_valid, err_overflow, err_underflow;
  logic [31:0] lat_cycles, lat_min, lat_max;
  logic [15:0] frame_cnt;
  logic [7:0]  last_result;

  logic        tready8, lat_valid8, ovf8, unf8;
  logic [7:0]  lat_cycles8, lat_min8, lat_max8, last_result8;
  logic [15:0] frame_cnt8;

  int checks = 0;
  int failures = 0;
  int tb_cyc = 0;

  typedef struct {
    logic [31:0] lat;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [15:0] fc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp8_q[$];

  always #5 ap_clk = ~ap_clk;

  finn_latency_sink dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .stall_en(stall_en),
    .lat_valid(lat_valid), .lat_cycles(lat_cycles), .lat_min(lat_min),
    .lat_max(lat_max), .frame_cnt(frame_cnt), .last_result(last_result),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  finn_latency_sink #(.CNT_W(8)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(tready8), .stall_en(stall_en),
    .lat_valid(lat_valid8), .lat_cycles(lat_cycles8), .lat_min(lat_min8),
    .lat_max(lat_max8), .frame_cnt(frame_cnt8), .last_result(last_result8),
    .err_overflow(ovf8), .err_underflow(unf8)
  );

  // Reference cycle count: 0 in the first cycle after reset release.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) tb_cyc <= 0;
    else           tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitors: pop and compare on every latency pulse.
  always @(negedge ap_clk) begin
    if (lat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got lat=%0d expected no sample", lat_cycles);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_lat", lat_cycles, e.lat);
        check("sample_min", lat_min, e.mn);
        check("sample_max", lat_max, e.mx);
        check("sample_frames", {16'd0, frame_cnt}, {16'd0, e.fc});
      end
    end
  end

  always @(negedge ap_clk) begin
    if (lat_valid8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample8: got lat=%0d expected no sample", lat_cycles8);
      end else begin
        logic [7:0] e8;
        e8 = exp8_q.pop_front();
        check("sample8_lat", {24'd0, lat_cycles8}, {24'd0, e8});
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (tb_cyc != n && guard < 5000) begin
      @(negedge ap_clk);
      guard++;
    end
    if (tb_cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: got cyc %0d expected %0d", tb_cyc, n);
    end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    clear = 1'b0;
    in_tvalid = 1'b0;
    in_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    stall_en = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic drive_frame(input int start);
    wait_cyc(start);
    in_tvalid = 1'b1;
    in_tready = 1'b1;
    repeat (10) @(negedge ap_clk);
    in_tvalid = 1'b0;
    in_tready = 1'b0;
  endtask

  task automatic out_beat(input int c, input logic [7:0] d);
    wait_cyc(c);
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    @(negedge ap_clk);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    // Reset values, observed while reset is held.
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("rst_lat_valid", {31'd0, lat_valid}, 32'd0);
    check("rst_lat_cycles", lat_cycles, 32'd0);
    check("rst_lat_min", lat_min, 32'hFFFF_FFFF);
    check("rst_lat_max", lat_max, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_last_result", {24'd0, last_result}, 32'd0);
    check("rst_err_overflow", {31'd0, err_overflow}, 32'd0);
    check("rst_err_underflow", {31'd0, err_underflow}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);

    // Two frames: 150-20 = 130, 220-84 = 136.
    do_reset();
    exp_q.push_back('{32'd130, 32'd130, 32'd130, 16'd1});
    exp_q.push_back('{32'd136, 32'd130, 32'd136, 16'd2});
    exp8_q.push_back(8'd130);
    exp8_q.push_back(8'd136);
    drive_frame(20);
    drive_frame(84);
    out_beat(150, 8'hA5);
    wait_cyc(155);
    check("last_result_1", {24'd0, last_result}, 32'h0000_00A5);
    out_beat(220, 8'h3C);
    wait_cyc(225);
    check("last_result_2", {24'd0, last_result}, 32'h0000_003C);
    check("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

    // Nine frame starts into an 8-deep FIFO with no outputs.
    do_reset();
    for (int i = 0; i < 8; i++) drive_frame(10 + 10 * i);
    check("ovf_before_ninth", {31'd0, err_overflow}, 32'd0);
    drive_frame(90);
    check("ovf_after_ninth", {31'd0, err_overflow}, 32'd1);
    check("ovf_no_underflow", {31'd0, err_underflow}, 32'd0);
    check("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    stall_en = 1'b1;
    wait_cyc(103);
    check("error_ignores_stall", {31'd0, s_axis_tready}, 32'd1);
    stall_en = 1'b0;

    // Output with no prior input, then clear.
    do_reset();
    out_beat(30, 8'h11);
    wait_cyc(33);
    check("unf_set", {31'd0, err_underflow}, 32'd1);
    check("unf_no_overflow", {31'd0, err_overflow}, 32'd0);
    wait_cyc(40);
    clear = 1'b1;
    @(negedge ap_clk);
    clear = 1'b0;
    check("clear_unf", {31'd0, err_underflow}, 32'd0);
    check("clear_lat_min", lat_min, 32'hFFFF_FFFF);
    stall_en = 1'b1;
    wait_cyc(47);
    check("idle_stall_low", {31'd0, s_axis_tready}, 32'd0);
    wait_cyc(48);
    check("idle_stall_high", {31'd0, s_axis_tready}, 32'd1);
    stall_en = 1'b0;

    // Counter wrap on the 8-bit instance: start 250, output 260 (cyc8 = 4).
    do_reset();
    exp_q.push_back('{32'd10, 32'd10, 32'd10, 16'd1});
    exp8_q.push_back(8'd10);
    drive_frame(250);
    out_beat(260, 8'h77);
    wait_cyc(265);

    // Stalled output: tvalid at cyc 123 (low bits 11), accepted at 124.
    do_reset();
    exp_q.push_back('{32'd24, 32'd24, 32'd24, 16'd1});
    exp8_q.push_back(8'd24);
    drive_frame(100);
    stall_en = 1'b1;
    wait_cyc(123);
    s_axis_tdata = 8'h5A;
    s_axis_tvalid = 1'b1;
    check("stall_tready_low", {31'd0, s_axis_tready}, 32'd0);
    @(negedge ap_clk);
    check("stall_tready_high", {31'd0, s_axis_tready}, 32'd1);
    @(negedge ap_clk);
    s_axis_tvalid = 1'b0;
    stall_en = 1'b0;
    wait_cyc(130);
    check("stall_last_result", {24'd0, last_result}, 32'h0000_005A);

    repeat (5) @(negedge ap_clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("scoreboard8_drained", exp8_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
